// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding select and countdown-scoreboard hazard detection at the
// decode/execute boundary. Register 0 is never forwarded or tracked.
module fwd_scoreboard_unit #(
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int NFWD   = 2,
    parameter int LD_LAT = 1,
    parameter int MC_LAT = 4,
    parameter int CW     = 3,
    parameter int SW     = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               issue_valid,
    input  logic [NSRC*AW-1:0] issue_src,
    input  logic [NSRC-1:0]    issue_src_used,
    input  logic               issue_wr,
    input  logic [AW-1:0]      issue_dst,
    input  logic [1:0]         issue_kind,
    input  logic               flush,
    input  logic [NFWD-1:0]    stage_wr,
    input  logic [NFWD*AW-1:0] stage_dst,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic               stall,
    output logic               issue_fire,
    output logic               mc_busy,
    output logic [NREG-1:0]    pending
);

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_MC   = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    kind_e         kind;
    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [CW-1:0] mc_cnt_q;
    logic [CW-1:0] mc_cnt_d;
    logic          raw_hit;
    logic          waw_hit;
    logic          struct_hit;
    logic [AW-1:0] src;
    logic [SW-1:0] sel;

    assign kind = kind_e'(issue_kind);

    // Stages are scanned oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_sel = '0;
        src     = '0;
        sel     = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src = issue_src[i*AW +: AW];
            sel = '0;
            if (issue_src_used[i] && src != '0) begin
                for (int unsigned j = 0; j < NFWD; j++) begin
                    if (stage_wr[NFWD-1-j] && stage_dst[(NFWD-1-j)*AW +: AW] == src)
                        sel = SW'(NFWD - j);
                end
            end
            fwd_sel[i*SW +: SW] = sel;
        end
    end

    always_comb begin
        raw_hit = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (issue_src_used[i] && issue_src[i*AW +: AW] != '0 &&
                cnt_q[issue_src[i*AW +: AW]] != '0)
                raw_hit = 1'b1;
        end
        waw_hit    = issue_wr && issue_dst != '0 && cnt_q[issue_dst] != '0;
        struct_hit = (kind == KIND_MC) && mc_cnt_q != '0;
        stall      = issue_valid && (raw_hit || waw_hit || struct_hit);
        issue_fire = issue_valid && !stall && !flush;
    end

    // Decrement-then-load ordering lets a fresh latency override the countdown.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++)
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
        mc_cnt_d = (mc_cnt_q != '0) ? mc_cnt_q - 1'b1 : '0;
        if (issue_fire && issue_wr && issue_dst != '0) begin
            if (kind == KIND_LOAD)
                cnt_d[issue_dst] = CW'(LD_LAT);
            else if (kind == KIND_MC)
                cnt_d[issue_dst] = CW'(MC_LAT);
        end
        if (issue_fire && kind == KIND_MC)
            mc_cnt_d = CW'(MC_LAT);
        cnt_d[0] = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
            mc_cnt_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
            mc_cnt_q <= mc_cnt_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 1; r < NREG; r++)
            pending[r] = (cnt_q[r] != '0);
    end

    assign mc_busy = (mc_cnt_q != '0);

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed scenarios followed by random traffic, all checked against a
// per-register latency model kept in plain integer arrays.
module tb_fwd_scoreboard_unit;

    localparam int NREG = 32, AW = 5, NSRC = 2, NFWD = 2;
    localparam int LD_LAT = 1, MC_LAT = 4, CW = 3, SW = 2;

    logic               CLK = 1'b0;
    logic               RST;
    logic               issue_valid;
    logic [NSRC*AW-1:0] issue_src;
    logic [NSRC-1:0]    issue_src_used;
    logic               issue_wr;
    logic [AW-1:0]      issue_dst;
    logic [1:0]         issue_kind;
    logic               flush;
    logic [NFWD-1:0]    stage_wr;
    logic [NFWD*AW-1:0] stage_dst;
    logic [NSRC*SW-1:0] fwd_sel;
    logic               stall;
    logic               issue_fire;
    logic               mc_busy;
    logic [NREG-1:0]    pending;

    int checks = 0;
    int errors = 0;
    int m_cnt [NREG];
    int m_mc;

    fwd_scoreboard_unit #(
        .NREG(NREG), .AW(AW), .NSRC(NSRC), .NFWD(NFWD),
        .LD_LAT(LD_LAT), .MC_LAT(MC_LAT), .CW(CW), .SW(SW)
    ) dut (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_src(issue_src),
        .issue_src_used(issue_src_used), .issue_wr(issue_wr), .issue_dst(issue_dst),
        .issue_kind(issue_kind), .flush(flush), .stage_wr(stage_wr),
        .stage_dst(stage_dst), .fwd_sel(fwd_sel), .stall(stall),
        .issue_fire(issue_fire), .mc_busy(mc_busy), .pending(pending)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int src_of(input int i);
        return int'(issue_src[i*AW +: AW]);
    endfunction

    function automatic logic [NSRC*SW-1:0] exp_fwd();
        logic [NSRC*SW-1:0] v = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (issue_src_used[i] && src_of(i) != 0) begin
                for (int k = NFWD - 1; k >= 0; k--)
                    if (stage_wr[k] && int'(stage_dst[k*AW +: AW]) == src_of(i))
                        v[i*SW +: SW] = SW'(k + 1);
            end
        end
        return v;
    endfunction

    function automatic logic exp_stall();
        logic hz = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (issue_src_used[i] && src_of(i) != 0 && m_cnt[src_of(i)] > 0) hz = 1'b1;
        if (issue_wr && issue_dst != 0 && m_cnt[issue_dst] > 0) hz = 1'b1;
        if (issue_kind == 2 && m_mc > 0) hz = 1'b1;
        return issue_valid && hz;
    endfunction

    function automatic logic exp_fire();
        return issue_valid && !exp_stall() && !flush;
    endfunction

    function automatic logic [NREG-1:0] exp_pending();
        logic [NREG-1:0] p = '0;
        for (int r = 1; r < NREG; r++) p[r] = (m_cnt[r] > 0);
        return p;
    endfunction

    task automatic settle();
        #2;
        chk("fwd_sel", 32'(fwd_sel), 32'(exp_fwd()));
        chk("stall", 32'(stall), 32'(exp_stall()));
        chk("issue_fire", 32'(issue_fire), 32'(exp_fire()));
        chk("mc_busy", 32'(mc_busy), 32'(m_mc > 0));
        chk("pending", 32'(pending), 32'(exp_pending()));
    endtask

    task automatic tick();
        logic f;
        f = exp_fire();
        @(posedge CLK);
        if (RST) begin
            for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
            m_mc = 0;
        end else begin
            for (int r = 0; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
            if (m_mc > 0) m_mc--;
            if (f && issue_wr && issue_dst != 0) begin
                if (issue_kind == 1) m_cnt[issue_dst] = LD_LAT;
                if (issue_kind == 2) m_cnt[issue_dst] = MC_LAT;
            end
            if (f && issue_kind == 2) m_mc = MC_LAT;
        end
        #1;
    endtask

    task automatic idle();
        RST = 0; issue_valid = 0; issue_src = '0; issue_src_used = '0;
        issue_wr = 0; issue_dst = '0; issue_kind = 0; flush = 0;
        stage_wr = '0; stage_dst = '0;
    endtask

    task automatic instr(input int kind, input int dst, input int s0, input int s1,
                         input logic [1:0] used);
        issue_valid = 1; issue_kind = 2'(kind); issue_wr = (dst >= 0);
        issue_dst = (dst >= 0) ? AW'(dst) : '0;
        issue_src[0 +: AW] = AW'(s0); issue_src[AW +: AW] = AW'(s1);
        issue_src_used = used;
    endtask

    initial begin
        idle();
        RST = 1;
        tick();
        settle();
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_mc_busy", 32'(mc_busy), 32'd0);
        tick();

        // ALU producer followed by a forwarded consumer
        idle(); instr(0, 3, 1, 2, 2'b11); settle();
        chk("add_fire", 32'(issue_fire), 32'd1);
        tick();
        idle(); instr(0, 4, 3, 0, 2'b01); stage_wr = 2'b01; stage_dst[0 +: AW] = 5'd3;
        settle();
        chk("sub_stall", 32'(stall), 32'd0);
        chk("sub_fwd", 32'(fwd_sel[1:0]), 32'd1);
        tick();

        // load-use
        idle(); instr(1, 5, 0, 0, 2'b00); settle(); tick();
        idle(); instr(0, 10, 5, 0, 2'b01); settle();
        chk("ldu_stall", 32'(stall), 32'd1);
        chk("ldu_pend5", 32'(pending[5]), 32'd1);
        tick();
        stage_wr = 2'b10; stage_dst[AW +: AW] = 5'd5; settle();
        chk("ldu_go", 32'(stall), 32'd0);
        chk("ldu_fwd", 32'(fwd_sel[1:0]), 32'd2);
        tick();

        // multicycle dependence and structural hazard
        idle(); instr(2, 7, 0, 0, 2'b00); settle(); tick();
        for (int j = 1; j <= 4; j++) begin
            idle();
            if (j == 2) instr(2, 8, 0, 0, 2'b00);
            else instr(0, 11, 7, 0, 2'b01);
            settle();
            chk("mc_stall", 32'(stall), 32'd1);
            chk("mc_busy", 32'(mc_busy), 32'd1);
            tick();
        end
        idle(); instr(0, 11, 7, 0, 2'b01); settle();
        chk("mc_release", 32'(issue_fire), 32'd1);
        tick();

        // register 0
        idle(); instr(0, 12, 0, 0, 2'b11); stage_wr = 2'b11; settle();
        chk("r0_fwd", 32'(fwd_sel), 32'd0);
        tick();
        idle(); instr(1, 0, 0, 0, 2'b00); settle(); tick();
        idle(); settle();
        chk("r0_pending", 32'(pending), 32'd0);

        // stage 0 priority on both operands
        idle(); instr(0, 13, 9, 9, 2'b11); stage_wr = 2'b11;
        stage_dst = {5'd9, 5'd9}; settle();
        chk("prio_fwd", 32'(fwd_sel), 32'b0101);
        tick();

        // reset while pending, then flush of a load
        idle(); instr(1, 6, 0, 0, 2'b00); settle(); tick();
        idle(); RST = 1; tick();
        idle(); instr(0, 14, 6, 0, 2'b01); settle();
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        idle(); instr(1, 6, 0, 0, 2'b00); flush = 1; settle();
        chk("flush_fire", 32'(issue_fire), 32'd0);
        tick();
        idle(); settle();
        chk("flush_pending", 32'(pending[6]), 32'd0);
        tick();

        for (int n = 0; n < 400; n++) begin
            idle();
            RST = ($urandom_range(0, 39) == 0);
            instr(int'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  2'($urandom_range(0, 3)));
            issue_valid = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 9) == 0);
            stage_wr = 2'($urandom_range(0, 3));
            stage_dst = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
